readout_mac: RTL

- Readout stage of the reservoir computer. Computes y = w0 + sum(x_i * w_i) over the 19 neuron outputs.
- Computes the error e = y_target - y.
- Driven by the same neuron outputs and weights as the weight-update (linear regression) block. y, err and err_valid are its training inputs.
- One time-shared multiplier evaluates one term per cycle under a start/busy/valid handshake.

---
 rtl/readout_mac.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/readout_mac.sv
`default_nettype none
// ============================================================================
// Module   : readout_mac
// Purpose  : Readout stage of the reservoir computer. Evaluates
//            y = w0 + sum(x_i * w_i) over N_NEURONS neuron outputs with a
//            single time-shared multiplier (one term per clock), then forms
//            the training error err = y_target - y. Both results are
//            saturated to X_W bits.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start          - request one evaluation (sampled in IDLE only)
//            training       - training-mode flag, captured at start
//            y_target       - target output, captured at start
//            x_bus          - packed neuron outputs x1..xN (x1 in LSBs)
//            w_bus          - packed weights w0..wN (bias w0 in LSBs)
//            busy           - evaluation in progress
//            y, err         - results, held between updates
//            y_valid        - one-cycle pulse when y/err update
//            err_valid      - y_valid qualified by captured training flag
// Revision : 1.0 - initial release
// ============================================================================
module readout_mac #(
    parameter int N_NEURONS = 19,
    parameter int X_W       = 16,
    parameter int X_FRAC    = 14,
    parameter int W_W       = 8,
    parameter int W_FRAC    = 6,
    parameter int ACC_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         training,
    input  logic [X_W-1:0]               y_target,
    input  logic [N_NEURONS*X_W-1:0]     x_bus,
    input  logic [(N_NEURONS+1)*W_W-1:0] w_bus,
    output logic                         busy,
    output logic [X_W-1:0]               y,
    output logic [X_W-1:0]               err,
    output logic                         y_valid,
    output logic                         err_valid
);

    localparam int c_IDX_W  = $clog2(N_NEURONS + 1);
    localparam int c_TAB    = 1 << c_IDX_W;
    localparam int c_PROD_W = X_W + W_W;

    localparam logic signed [ACC_W-1:0] c_SAT_MAX =
        {{(ACC_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN =
        {{(ACC_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                         r_state;
    logic [N_NEURONS*X_W-1:0]       r_x;
    logic [(N_NEURONS+1)*W_W-1:0]   r_w;
    logic [X_W-1:0]                 r_ytgt;
    logic                           r_train;
    logic signed [ACC_W-1:0]        r_acc;
    logic [c_IDX_W-1:0]             r_idx;

    // Operand lookup tables indexed directly by r_idx. Entry 0 of the x table
    // is unused (bias slot), and entries past N_NEURONS are tied to zero so
    // every index value is defined.
    logic signed [X_W-1:0] w_x_tab [0:c_TAB-1];
    logic signed [W_W-1:0] w_w_tab [0:c_TAB-1];

    generate
        for (genvar gi = 0; gi < c_TAB; gi++) begin : g_tab
            if (gi >= 1 && gi <= N_NEURONS) begin : g_x
                assign w_x_tab[gi] = r_x[(gi-1)*X_W +: X_W];
            end else begin : g_x_zero
                assign w_x_tab[gi] = '0;
            end
            if (gi <= N_NEURONS) begin : g_w
                assign w_w_tab[gi] = r_w[gi*W_W +: W_W];
            end else begin : g_w_zero
                assign w_w_tab[gi] = '0;
            end
        end
    endgenerate

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_bias;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_ys;
    logic [X_W-1:0]             w_y_sat;
    logic signed [ACC_W-1:0]    w_diff;
    logic [X_W-1:0]             w_err_sat;

    function automatic logic [X_W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
        if (v > c_SAT_MAX)
            f_sat = c_SAT_MAX[X_W-1:0];
        else if (v < c_SAT_MIN)
            f_sat = c_SAT_MIN[X_W-1:0];
        else
            f_sat = v[X_W-1:0];
    endfunction

    assign w_prod = w_x_tab[r_idx] * w_w_tab[r_idx];

    // Bias is aligned to the product's fixed-point position (X_FRAC+W_FRAC).
    assign w_bias = {{(ACC_W-W_W){r_w[W_W-1]}}, r_w[W_W-1:0]} << X_FRAC;

    assign w_term = (r_idx == '0) ? w_bias
                                  : {{(ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};

    // Drop the weight fraction bits to return to the X_FRAC format.
    assign w_ys    = r_acc >>> W_FRAC;
    assign w_y_sat = f_sat(w_ys);

    // Error uses the already-saturated y, widened so the difference cannot wrap.
    assign w_diff    = {{(ACC_W-X_W){r_ytgt[X_W-1]}}, r_ytgt}
                     - {{(ACC_W-X_W){w_y_sat[X_W-1]}}, w_y_sat};
    assign w_err_sat = f_sat(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_w       <= '0;
            r_ytgt    <= '0;
            r_train   <= 1'b0;
            r_acc     <= '0;
            r_idx     <= '0;
            busy      <= 1'b0;
            y         <= '0;
            err       <= '0;
            y_valid   <= 1'b0;
            err_valid <= 1'b0;
        end else begin
            y_valid   <= 1'b0;
            err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x_bus;
                        r_w     <= w_bus;
                        r_ytgt  <= y_target;
                        r_train <= training;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (r_idx == c_IDX_W'(N_NEURONS))
                        r_state <= S_OUT;
                end
                S_OUT: begin
                    y         <= w_y_sat;
                    err       <= w_err_sat;
                    y_valid   <= 1'b1;
                    err_valid <= r_train;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
